// File: rtl/sweep_ctrl.sv
// Frequency-sweep scheduler: steps the phase-controller divider from a start
// value to a stop value, holding each value for a number of waveform periods.
module sweep_ctrl #(
   parameter int W  = 8,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          abort,
   input  logic [W-1:0]  cfg_start,
   input  logic [W-1:0]  cfg_stop,
   input  logic [W-1:0]  cfg_step,
   input  logic [DW-1:0] cfg_dwell,
   input  logic [1:0]    cfg_mode,
   input  logic          phase_wrap,
   output logic [W-1:0]  freq_out,
   output logic          step_strobe,
   output logic          busy,
   output logic          done,
   output logic          dir
);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      DWELL,
      DONE
   } state_t;

   localparam logic [1:0] MODE_REPEAT = 2'b01;
   localparam logic [1:0] MODE_PPONG  = 2'b10;

   state_t        state_q;
   logic [W-1:0]  start_q;
   logic [W-1:0]  stop_q;
   logic [W-1:0]  end_q;
   logic [W-1:0]  step_q;
   logic [DW-1:0] dwell_q;
   logic [DW-1:0] wrap_q;
   logic [1:0]    mode_q;
   logic          dir0_q;
   logic [W-1:0]  freq_q;
   logic          strobe_q;
   logic          busy_q;
   logic          done_q;
   logic          dir_q;

   logic [DW:0]   wrap_d;
   logic          fire;
   logic [W-1:0]  pp_end;
   logic [W-1:0]  step_d;
   logic [W-1:0]  pp_d;

   // Step toward tgt by stp, computed one bit wider so overshoot, overflow
   // and underflow all clamp to the target.
   function automatic logic [W-1:0] step_to(
      input logic [W-1:0] cur,
      input logic [W-1:0] tgt,
      input logic [W-1:0] stp,
      input logic         up
   );
      logic [W:0] t;
      if (up) begin
         t = {1'b0, cur} + {1'b0, stp};
         if (t > {1'b0, tgt}) t = {1'b0, tgt};
      end else begin
         t = {1'b0, cur} - {1'b0, stp};
         if (t[W] || (t < {1'b0, tgt})) t = {1'b0, tgt};
      end
      return t[W-1:0];
   endfunction

   always_comb begin
      wrap_d = {1'b0, wrap_q} + 1'b1;
      fire   = phase_wrap && (wrap_d == {1'b0, dwell_q});
      pp_end = (end_q == stop_q) ? start_q : stop_q;
      step_d = step_to(freq_q, end_q, step_q, dir_q);
      pp_d   = step_to(freq_q, pp_end, step_q, ~dir_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         start_q  <= '0;
         stop_q   <= '0;
         end_q    <= '0;
         step_q   <= '0;
         dwell_q  <= '0;
         wrap_q   <= '0;
         mode_q   <= '0;
         dir0_q   <= 1'b0;
         freq_q   <= '0;
         strobe_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         dir_q    <= 1'b0;
      end else begin
         strobe_q <= 1'b0;
         done_q   <= 1'b0;
         if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
         end else begin
            unique case (state_q)
               IDLE: begin
                  if (start) begin
                     start_q <= cfg_start;
                     stop_q  <= cfg_stop;
                     end_q   <= cfg_stop;
                     step_q  <= (cfg_step == '0) ? W'(1) : cfg_step;
                     dwell_q <= (cfg_dwell == '0) ? DW'(1) : cfg_dwell;
                     mode_q  <= cfg_mode;
                     dir0_q  <= (cfg_start <= cfg_stop);
                     dir_q   <= (cfg_start <= cfg_stop);
                     busy_q  <= 1'b1;
                     state_q <= LOAD;
                  end
               end
               LOAD: begin
                  freq_q   <= start_q;
                  strobe_q <= 1'b1;
                  wrap_q   <= '0;
                  state_q  <= DWELL;
               end
               DWELL: begin
                  if (fire) begin
                     wrap_q <= '0;
                     if (freq_q != end_q) begin
                        freq_q   <= step_d;
                        strobe_q <= 1'b1;
                     end else if (mode_q == MODE_PPONG) begin
                        end_q    <= pp_end;
                        dir_q    <= ~dir_q;
                        freq_q   <= pp_d;
                        strobe_q <= 1'b1;
                     end else if (mode_q == MODE_REPEAT) begin
                        freq_q   <= start_q;
                        dir_q    <= dir0_q;
                        end_q    <= stop_q;
                        strobe_q <= 1'b1;
                     end else begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                     end
                  end else if (phase_wrap) begin
                     wrap_q <= wrap_d[DW-1:0];
                  end
               end
               DONE: begin
                  state_q <= IDLE;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign freq_out    = freq_q;
   assign step_strobe = strobe_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign dir         = dir_q;

endmodule

// File: tb/tb_sweep_ctrl.sv
// Directed testbench for sweep_ctrl: one task per scenario with
// hand-computed frequency sequences captured on step_strobe.
module tb_sweep_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [7:0]  cfg_start = '0;
   logic [7:0]  cfg_stop = '0;
   logic [7:0]  cfg_step = '0;
   logic [15:0] cfg_dwell = '0;
   logic [1:0]  cfg_mode = '0;
   logic        phase_wrap = 1'b0;
   logic [7:0]  freq_out;
   logic        step_strobe;
   logic        busy;
   logic        done;
   logic        dir;

   int checks = 0;
   int errors = 0;

   logic [7:0] cap[$];
   int         done_tot = 0;
   int         bad_chg = 0;
   logic [7:0] last_f = '0;

   sweep_ctrl #(.W(8), .DW(16)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_step(cfg_step),
      .cfg_dwell(cfg_dwell), .cfg_mode(cfg_mode), .phase_wrap(phase_wrap),
      .freq_out(freq_out), .step_strobe(step_strobe), .busy(busy),
      .done(done), .dir(dir)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (step_strobe) cap.push_back(freq_out);
      if (done) done_tot++;
      if (!rst && !step_strobe && freq_out !== last_f) bad_chg++;
      last_f = freq_out;
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic go(input logic [7:0] s, input logic [7:0] e,
                     input logic [7:0] st, input logic [15:0] dw,
                     input logic [1:0] m);
      cfg_start = s; cfg_stop = e; cfg_step = st;
      cfg_dwell = dw; cfg_mode = m;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wrap(input int n = 1);
      repeat (n) begin
         phase_wrap = 1'b1;
         tick();
         phase_wrap = 1'b0;
         tick();
      end
   endtask

   task automatic do_abort();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(2);
      checks++;
      if ({freq_out, step_strobe, busy, done, dir} !== 12'h0) begin
         errors++;
         $display("FAIL reset_outputs: got %h required 000", {freq_out, step_strobe, busy, done, dir});
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_up_single();
      int b, d, sz;
      logic [7:0] ev[$];
      ev = '{8'd10, 8'd14, 8'd18, 8'd20};
      b = cap.size(); d = done_tot;
      go(10, 20, 4, 2, 2'b00);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL up_busy_load: got %b required 1", busy); end
      tick();
      checks++;
      if (step_strobe !== 1'b1 || freq_out !== 8'd10) begin
         errors++;
         $display("FAIL up_first: strobe %b freq %0d required 1 10", step_strobe, freq_out);
      end
      for (int i = 1; i <= 8; i++) begin
         wrap(1);
         sz = 1 + i / 2;
         if (sz > 4) sz = 4;
         checks++;
         if (cap.size() - b != sz) begin
            errors++;
            $display("FAIL up_hold wrap %0d: got %0d values required %0d", i, cap.size() - b, sz);
         end
      end
      checks++;
      if (cap.size() - b != ev.size()) begin
         errors++; $display("FAIL up_count: got %0d required %0d", cap.size() - b, ev.size());
      end else foreach (ev[i]) begin
         checks++;
         if (cap[b+i] !== ev[i]) begin errors++; $display("FAIL up_seq[%0d]: got %0d required %0d", i, cap[b+i], ev[i]); end
      end
      checks++;
      if (done_tot - d != 1 || busy !== 1'b0 || freq_out !== 8'd20) begin
         errors++;
         $display("FAIL up_end: done %0d busy %b freq %0d required 1 0 20", done_tot - d, busy, freq_out);
      end
   endtask

   task automatic test_down_clamp();
      int b, d;
      logic [7:0] ev[$];
      ev = '{8'd20, 8'd15, 8'd10};
      b = cap.size(); d = done_tot;
      go(20, 10, 5, 1, 2'b00);
      tick();
      checks++;
      if (dir !== 1'b0) begin errors++; $display("FAIL down_dir: got %b required 0", dir); end
      wrap(3);
      checks++;
      if (cap.size() - b != ev.size()) begin
         errors++; $display("FAIL down_count: got %0d required %0d", cap.size() - b, ev.size());
      end else foreach (ev[i]) begin
         checks++;
         if (cap[b+i] !== ev[i]) begin errors++; $display("FAIL down_seq[%0d]: got %0d required %0d", i, cap[b+i], ev[i]); end
      end
      checks++;
      if (done_tot - d != 1) begin errors++; $display("FAIL down_done: got %0d required 1", done_tot - d); end
      ev = '{8'd250, 8'd255};
      b = cap.size(); d = done_tot;
      go(250, 255, 10, 1, 2'b00);
      tick();
      checks++;
      if (dir !== 1'b1) begin errors++; $display("FAIL ovf_dir: got %b required 1", dir); end
      wrap(2);
      checks++;
      if (cap.size() - b != ev.size()) begin
         errors++; $display("FAIL ovf_count: got %0d required %0d", cap.size() - b, ev.size());
      end else foreach (ev[i]) begin
         checks++;
         if (cap[b+i] !== ev[i]) begin errors++; $display("FAIL ovf_seq[%0d]: got %0d required %0d", i, cap[b+i], ev[i]); end
      end
      checks++;
      if (done_tot - d != 1 || freq_out !== 8'd255) begin
         errors++; $display("FAIL ovf_end: done %0d freq %0d required 1 255", done_tot - d, freq_out);
      end
   endtask

   task automatic test_pingpong();
      int b, d;
      logic [7:0] ev[$];
      logic       ed[$];
      ev = '{8'd0, 8'd4, 8'd8, 8'd4, 8'd0, 8'd4, 8'd8};
      ed = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      b = cap.size(); d = done_tot;
      go(0, 8, 4, 1, 2'b10);
      tick();
      foreach (ev[i]) begin
         if (i > 0) wrap(1);
         checks++;
         if (freq_out !== ev[i] || dir !== ed[i]) begin
            errors++;
            $display("FAIL pp_step[%0d]: freq %0d dir %b required %0d %b", i, freq_out, dir, ev[i], ed[i]);
         end
      end
      checks++;
      if (cap.size() - b != ev.size() || busy !== 1'b1 || done_tot != d) begin
         errors++;
         $display("FAIL pp_status: strobes %0d busy %b done %0d required 7 1 0", cap.size() - b, busy, done_tot - d);
      end
      do_abort();
   endtask

   task automatic test_repeat();
      int b;
      logic [7:0] ev[$];
      ev = '{8'd0, 8'd4, 8'd8, 8'd0, 8'd4, 8'd8};
      b = cap.size();
      go(0, 8, 4, 1, 2'b01);
      tick();
      wrap(5);
      checks++;
      if (cap.size() - b != ev.size()) begin
         errors++; $display("FAIL rep_count: got %0d required %0d", cap.size() - b, ev.size());
      end else foreach (ev[i]) begin
         checks++;
         if (cap[b+i] !== ev[i]) begin errors++; $display("FAIL rep_seq[%0d]: got %0d required %0d", i, cap[b+i], ev[i]); end
      end
      checks++;
      if (dir !== 1'b1 || busy !== 1'b1) begin
         errors++; $display("FAIL rep_status: dir %b busy %b required 1 1", dir, busy);
      end
      do_abort();
   endtask

   task automatic test_degenerate();
      int b, d;
      logic [7:0] ev[$];
      ev = '{8'd3, 8'd4, 8'd5};
      b = cap.size(); d = done_tot;
      go(3, 5, 0, 0, 2'b00);
      tick();
      wrap(2);
      checks++;
      if (cap.size() - b != ev.size()) begin
         errors++; $display("FAIL deg_count: got %0d required %0d", cap.size() - b, ev.size());
      end else foreach (ev[i]) begin
         checks++;
         if (cap[b+i] !== ev[i]) begin errors++; $display("FAIL deg_seq[%0d]: got %0d required %0d", i, cap[b+i], ev[i]); end
      end
      checks++;
      if (busy !== 1'b1 || done_tot != d) begin
         errors++; $display("FAIL deg_busy: busy %b done %0d required 1 0", busy, done_tot - d);
      end
      wrap(1);
      checks++;
      if (done_tot - d != 1 || busy !== 1'b0) begin
         errors++; $display("FAIL deg_done: done %0d busy %b required 1 0", done_tot - d, busy);
      end
      b = cap.size(); d = done_tot;
      go(7, 7, 5, 1, 2'b00);
      tick();
      wrap(1);
      checks++;
      if (cap.size() - b != 1 || cap[cap.size()-1] !== 8'd7 || done_tot - d != 1 || freq_out !== 8'd7) begin
         errors++;
         $display("FAIL eq_single: strobes %0d freq %0d done %0d required 1 7 1", cap.size() - b, freq_out, done_tot - d);
      end
   endtask

   task automatic test_abort();
      int b, d, b2;
      b = cap.size(); d = done_tot;
      go(10, 20, 4, 2, 2'b00);
      tick();
      wrap(2);
      checks++;
      if (freq_out !== 8'd14) begin errors++; $display("FAIL abort_pre: got %0d required 14", freq_out); end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++;
      if (busy !== 1'b0 || freq_out !== 8'd14) begin
         errors++; $display("FAIL abort_idle: busy %b freq %0d required 0 14", busy, freq_out);
      end
      wrap(4);
      checks++;
      if (cap.size() - b != 2 || done_tot != d || freq_out !== 8'd14) begin
         errors++;
         $display("FAIL abort_after: strobes %0d done %0d freq %0d required 2 0 14", cap.size() - b, done_tot - d, freq_out);
      end
      b2 = cap.size();
      cfg_start = 8'd1; cfg_stop = 8'd9; cfg_step = 8'd1;
      cfg_dwell = 16'd1; cfg_mode = 2'b00;
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      tick(3);
      checks++;
      if (busy !== 1'b0 || cap.size() != b2) begin
         errors++; $display("FAIL start_abort: busy %b strobes %0d required 0 0", busy, cap.size() - b2);
      end
   endtask

   task automatic test_reset_mid();
      int b, d;
      logic [7:0] ev[$];
      ev = '{8'd10, 8'd14, 8'd18, 8'd20};
      go(10, 20, 4, 2, 2'b00);
      tick();
      wrap(3);
      checks++;
      if (dir !== 1'b1 || busy !== 1'b1 || freq_out !== 8'd14) begin
         errors++; $display("FAIL rst_pre: dir %b busy %b freq %0d required 1 1 14", dir, busy, freq_out);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (freq_out !== 8'd0 || busy !== 1'b0 || dir !== 1'b0) begin
         errors++; $display("FAIL rst_async: freq %0d busy %b dir %b required 0 0 0", freq_out, busy, dir);
      end
      tick(2);
      rst = 1'b0;
      tick();
      b = cap.size(); d = done_tot;
      go(10, 20, 4, 1, 2'b00);
      tick();
      wrap(1);
      go(100, 200, 1, 1, 2'b10);
      wrap(3);
      checks++;
      if (cap.size() - b != ev.size()) begin
         errors++; $display("FAIL clean_count: got %0d required %0d", cap.size() - b, ev.size());
      end else foreach (ev[i]) begin
         checks++;
         if (cap[b+i] !== ev[i]) begin errors++; $display("FAIL clean_seq[%0d]: got %0d required %0d", i, cap[b+i], ev[i]); end
      end
      checks++;
      if (done_tot - d != 1 || busy !== 1'b0 || freq_out !== 8'd20) begin
         errors++; $display("FAIL clean_end: done %0d busy %b freq %0d required 1 0 20", done_tot - d, busy, freq_out);
      end
   endtask

   task automatic test_freq_stable();
      checks++;
      if (bad_chg != 0) begin
         errors++; $display("FAIL freq_unflagged_change: got %0d required 0", bad_chg);
      end
   endtask

   initial begin
      test_reset();
      test_up_single();
      test_down_clamp();
      test_pingpong();
      test_repeat();
      test_degenerate();
      test_abort();
      test_reset_mid();
      test_freq_stable();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
